// File: rtl/iter_array_multiplier.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier, one partial-product row per clock,
// valid/ready on both sides. Define ITER_MUL_SIGNED_EN for per-operation two's-complement mode.
module iter_array_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef ITER_MUL_SIGNED_EN
   input  logic               in_signed,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 w_accept;
   logic                 w_done_take;
   logic                 w_last_row;
   logic [2*WIDTH-1:0]   w_ext_a;
   logic [2*WIDTH-1:0]   w_row;
   logic [2*WIDTH-1:0]   w_acc_nxt;

`ifdef ITER_MUL_SIGNED_EN
   logic                 r_sgn;
`endif

   assign w_accept    = in_valid && (r_state == IDLE);
   assign w_done_take = out_ready && (r_state == DONE);
   assign w_last_row  = (r_cnt == CW'(WIDTH-1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)    w_state_nxt = BUSY;
         BUSY:    if (w_last_row)  w_state_nxt = DONE;
         DONE:    if (w_done_take) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Single adder row: the shifted multiplicand is added when the current multiplier bit is set.
   // In signed mode the top row carries negative weight, so it is subtracted instead.
`ifdef ITER_MUL_SIGNED_EN
   assign w_ext_a = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
   assign w_row   = w_ext_a << r_cnt;

   always_comb begin
      w_acc_nxt = r_acc;
      if (r_b[r_cnt]) begin
         if (r_sgn && w_last_row) w_acc_nxt = r_acc - w_row;
         else                     w_acc_nxt = r_acc + w_row;
      end
   end
`else
   assign w_ext_a = {{WIDTH{1'b0}}, r_a};
   assign w_row   = w_ext_a << r_cnt;

   always_comb begin
      w_acc_nxt = r_acc;
      if (r_b[r_cnt]) w_acc_nxt = r_acc + w_row;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_acc <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            BUSY: begin
               r_acc <= w_acc_nxt;
               if (!w_last_row) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ITER_MUL_SIGNED_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_sgn <= 1'b0;
      else if (w_accept) r_sgn <= in_signed;
   end
`endif

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state == BUSY);
   assign out_p     = r_acc;

endmodule

// File: tb/tb_iter_array_multiplier.sv
// Directed bench for iter_array_multiplier: WIDTH=4 instance for products, latency,
// backpressure and reset; WIDTH=8 instance for the wide product and issue interval.
module tb_iter_array_multiplier;

   logic clk;
   logic rst;

   logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4, sgn4;
   logic [3:0] a4, b4;
   logic [7:0] p4;

   logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8, sgn8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;

   int checks;
   int errors;

   iter_array_multiplier #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .a         (a4),
      .b         (b4),
`ifdef ITER_MUL_SIGNED_EN
      .in_signed (sgn4),
`endif
      .out_valid (out_valid4),
      .out_ready (out_ready4),
      .out_p     (p4),
      .busy      (busy4)
   );

   iter_array_multiplier #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
`ifdef ITER_MUL_SIGNED_EN
      .in_signed (sgn8),
`endif
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .out_p     (p8),
      .busy      (busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       sgn;
      logic [7:0] p;
      string      name;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair, check busy, latency and product, then complete the output handshake.
   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                         input logic [7:0] exp, input string name);
      int n;
      n = 0;
      while (!in_ready4 && n < 50) begin tick(); n++; end
      chk({name, " in_ready"}, 64'(in_ready4), 64'd1);
      a4 = ta; b4 = tb_; sgn4 = ts; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0; a4 = ~ta; b4 = ~tb_; sgn4 = ~ts;
      chk({name, " busy"}, 64'(busy4), 64'd1);
      n = 0;
      while (!out_valid4 && n < 50) begin tick(); n++; end
      chk({name, " latency"}, 64'(n), 64'd4);
      chk({name, " product"}, 64'(p4), 64'(exp));
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      chk({name, " back to idle"}, 64'({in_ready4, out_valid4}), 64'b10);
   endtask

   initial begin
      vec_t vecs[$];
      logic [7:0] held;
      int acc_t[$];
      int n;
      logic prev_busy;

      checks = 0; errors = 0;
      rst = 1'b1;
      in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; sgn4 = 0;
      in_valid8 = 0; out_ready8 = 0; a8 = 0; b8 = 0; sgn8 = 0;

      vecs.push_back('{4'd7,  4'd5,  1'b0, 8'h23, "7x5"});
      vecs.push_back('{4'd8,  4'd9,  1'b0, 8'h48, "8x9"});
      vecs.push_back('{4'd15, 4'd15, 1'b0, 8'hE1, "15x15"});
      vecs.push_back('{4'd1,  4'd0,  1'b0, 8'h00, "1x0"});
      vecs.push_back('{4'd0,  4'd9,  1'b0, 8'h00, "0x9"});
`ifdef ITER_MUL_SIGNED_EN
      vecs.push_back('{4'h8, 4'h7, 1'b1, 8'hC8, "s -8x7"});
      vecs.push_back('{4'hF, 4'hF, 1'b1, 8'h01, "s -1x-1"});
      vecs.push_back('{4'h8, 4'h8, 1'b1, 8'h40, "s -8x-8"});
      vecs.push_back('{4'h8, 4'h7, 1'b0, 8'h38, "u 8x7"});
      vecs.push_back('{4'h3, 4'hE, 1'b1, 8'hFA, "s 3x-2"});
`endif

      tick(); tick();
      chk("reset state w4", 64'({in_ready4, out_valid4, busy4, p4}), {53'd0, 3'b100, 8'h00});
      chk("reset state w8", 64'({in_ready8, out_valid8, busy8, p8}), {45'd0, 3'b100, 16'h0000});
      rst = 1'b0;
      tick();

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].p, vecs[i].name);

      // Backpressure: product held 20 cycles while inputs churn.
      a4 = 4'd6; b4 = 4'd7; sgn4 = 1'b0; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      n = 0;
      while (!out_valid4 && n < 50) begin tick(); n++; end
      chk("bp product", 64'(p4), 64'h2A);
      held = p4;
      for (int i = 0; i < 20; i++) begin
         a4 = 4'($urandom); b4 = 4'($urandom); in_valid4 = 1'($urandom);
         tick();
         chk("bp hold", 64'({out_valid4, in_ready4, busy4, p4}), {53'd0, 3'b100, held});
      end
      in_valid4 = 1'b0;
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      run_op(4'd5, 4'd3, 1'b0, 8'h0F, "after bp 5x3");

      // Reset two cycles after accepting 15x15.
      a4 = 4'd15; b4 = 4'd15; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("midop reset", 64'({in_ready4, out_valid4, busy4, p4}), {53'd0, 3'b100, 8'h00});
      tick();
      rst = 1'b0;
      tick();
      chk("after reset no output", 64'(out_valid4), 64'd0);
      run_op(4'd3, 4'd3, 1'b0, 8'h09, "after rst 3x3");

      // WIDTH=8 back-to-back with out_ready held high.
      a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1; out_ready8 = 1'b1;
      prev_busy = 1'b0;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (busy8 && !prev_busy) acc_t.push_back(c);
         if (out_valid8) chk("w8 FFxFF", 64'(p8), 64'hFE01);
         prev_busy = busy8;
      end
      in_valid8 = 1'b0;
      chk("w8 accept count", 64'(acc_t.size() >= 4), 64'd1);
      if (acc_t.size() >= 4) begin
         for (int i = 1; i < 4; i++) chk("w8 issue interval", 64'(acc_t[i] - acc_t[i-1]), 64'd10);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
